nol_seq_det_101_mealy: RTL and testbench
========================================

# nol_seq_det_101_mealy

Serial-bit pattern detector that asserts a Mealy output when the input stream completes the pattern 1-0-1, non-overlapping by default. It is a single-clock control block fed one bit per clock from an upstream serial source. Its detect pulse goes to downstream logic that samples on the same clock edge.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset; one clock domain.
- in  input  1  serial data bit, sampled on each rising edge of clk.
- out  output  1  Mealy detect flag; high while the current in bit completes 1-0-1.

## Operation
- State register, 2 bits, three encoded states:
  - IDLE: no useful prefix.
  - S1: last relevant bit was 1.
  - S10: prefix 1-0 held.
  - The fourth encoding is illegal and recovers to IDLE on the next edge with out=0.
- Transitions (in=0 / in=1):
  - IDLE: IDLE / S1.
  - S1: S10 / S1.
  - S10: IDLE / IDLE. This is the match; in overlap mode it goes to S1 instead (see Configuration).
- Output: out = (state==S10) && (in==1) && rstn. It is purely combinational from the registered state and the live input, with no output register.
- Non-overlapping rule: after a match, the completing 1 is consumed. A new match needs a fresh full 1-0-1.
- No enable, no input qualification. Every rising edge consumes one bit.

## Timing
- Reset: rstn low forces state=IDLE immediately, asynchronously. out is held 0 for the whole time rstn is low, regardless of in.
- Reset release: the first rising edge with rstn high consumes the first bit. No bit is lost or extra bit inserted at deassertion.
- Latency: out rises in the same cycle that the third pattern bit is present on in, after combinational delay.
  - Downstream must sample it at the rising edge that consumes that bit.
  - out stays high until in or state changes.
- out is a single-cycle pulse per match, given in changes once per cycle after the clock edge.
- Glitches are possible on out while in settles. Consumers must sample synchronously.
- Reset mid-pattern, e.g. after 1-0: partial progress is discarded. A following 1 does not match.

## Configuration
- Macro NOL_SEQ_DET_101_MEALY_OVERLAP_EN.
- Undefined (default): non-overlapping. The S10 plus in=1 transition goes to IDLE.
- Defined: overlapping. The S10 plus in=1 transition goes to S1, so the final 1 of a match starts the next pattern.
- All other states, transitions, reset and output timing are identical in both builds.

## Test plan
- Reset: hold rstn=0 for 4 cycles while driving in=1,0,1,1 -> out=0 throughout and the state stays IDLE. On release with stream 1,0,1 -> out=1 on the 3rd bit only.
- Non-overlap: stream 1,0,1,0,1 after reset -> out high only during bit 3.
  - With NOL_SEQ_DET_101_MEALY_OVERLAP_EN defined, out is high during bits 3 and 5.
- Prefix handling: stream 1,1,0,1 -> out high on bit 4 only. Stream 1,0,0,1 -> out never high. Stream 0,0,0 -> out never high.
- Reset mid-operation: stream 1,0, then pulse rstn low between edges, then bit 1 -> out stays 0. A following 0,1 -> out high on that last 1.
- Random soak: 40+ $random bits after 4-cycle reset, compared each rising edge against a behavioral reference model in the bench.
  - Model: non-overlap counter of 1-0-1.
  - Any mismatch in out is a failure.
  - Run once per configuration.

Source files
------------

// File: rtl/nol_seq_det_101_mealy.sv
// nol_seq_det_101_mealy: Mealy detector for the serial pattern 1-0-1, non-overlapping by default.
// Define NOL_SEQ_DET_101_MEALY_OVERLAP_EN to let the final 1 of a match start the next pattern.
module nol_seq_det_101_mealy (
  input  logic clk,
  input  logic rstn,
  input  logic in,
  output logic out
);
  typedef enum logic [1:0] {IDLE = 2'b00, S1 = 2'b01, S10 = 2'b10, ILL = 2'b11} state_t;
  state_t state_q, state_d, match_next;
`ifdef NOL_SEQ_DET_101_MEALY_OVERLAP_EN
  assign match_next = S1;
`else
  assign match_next = IDLE;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = in ? S1 : IDLE;
      S1:      state_d = in ? S1 : S10;
      S10:     state_d = in ? match_next : IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign out = (state_q == S10) && in && rstn;
endmodule

// File: tb/tb_nol_seq_det_101_mealy.sv
// tb_nol_seq_det_101_mealy: directed and random checks of the 1-0-1 detector against a bit-history model.
module tb_nol_seq_det_101_mealy;
  logic clk, rstn, in, out;
  int checks = 0, failures = 0;
  logic hist[$];
`ifdef NOL_SEQ_DET_101_MEALY_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  nol_seq_det_101_mealy dut (.clk(clk), .rstn(rstn), .in(in), .out(out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Expected detect: the bits seen since the last reset/consumed match end in 1,0 and this bit is 1.
  function automatic logic model_exp(input logic b);
    int n = hist.size();
    return rstn && n >= 2 && hist[n-2] == 1'b1 && hist[n-1] == 1'b0 && b;
  endfunction

  function automatic void model_push(input logic b);
    logic m = model_exp(b);
    if (m && !OVL) hist.delete();
    else begin
      hist.push_back(b);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  endfunction

  task automatic step(input string tag, input logic b, input logic e);
    in = b;
    @(negedge clk);
    chk(tag, out, e);
    model_push(b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    logic [3:0] pat = 4'b1101;
    rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in = pat[i];
      @(negedge clk);
      chk("reset_out", out, 1'b0);
      chk("reset_state", dut.state_q == 2'b00, 1'b1);
      @(posedge clk);
      #1;
    end
    rstn = 1'b1;
    hist.delete();
  endtask

  task automatic seq(input string tag, input logic [7:0] bits, input logic [7:0] exp, input int n);
    for (int i = 0; i < n; i++) step(tag, bits[i], exp[i]);
  endtask

  initial begin
    logic b;
    rstn = 1'b0;
    in = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    seq("release_101", 8'b101, 8'b100, 3);
    do_reset();
    seq("overlap_10101", 8'b10101, {3'b0, OVL, 4'b0100}, 5);
    do_reset();
    seq("prefix_1101", 8'b1011, 8'b1000, 4);
    do_reset();
    seq("prefix_1001", 8'b1001, 8'b0000, 4);
    do_reset();
    seq("zeros_000", 8'b000, 8'b000, 3);
    do_reset();
    seq("mid_pre", 8'b01, 8'b00, 2);
    rstn = 1'b0;
    in = 1'b1;
    #1;
    chk("mid_rst_out", out, 1'b0);
    #1;
    rstn = 1'b1;
    hist.delete();
    seq("mid_post", 8'b101, 8'b100, 3);
    do_reset();
    repeat (64) begin
      b = 1'($urandom % 2);
      step("random", b, model_exp(b));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
